// File: rtl/stage_if_prefetch_if.sv
// Fetch-stage bundle: instruction-memory request/response channels plus the
// ID-side redirect and valid/ready handshake.
interface stage_if_prefetch_if #(
  parameter int unsigned IMEM_AW = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [IMEM_AW-1:0] imem_req_addr;
  logic               imem_resp_valid;
  logic [31:0]        imem_resp_data;
  logic               ctrl_pc_src_D;
  logic [31:0]        NPC_D;
  logic               ready_D;
  logic               valid_F;
  logic [31:0]        IR_F;
  logic [31:0]        PCInc4_F;
  logic [31:0]        PC;

  modport master (
    output imem_req_valid, imem_req_addr, valid_F, IR_F, PCInc4_F, PC,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           ctrl_pc_src_D, NPC_D, ready_D
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, valid_F, IR_F, PCInc4_F, PC,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           ctrl_pc_src_D, NPC_D, ready_D
  );
endinterface

// File: rtl/stage_if_prefetch.sv
// Prefetching IF stage: credit-limited fetch from a variable-latency memory into
// an in-order queue, presented to ID via valid/ready; ID redirects flush everything.
module stage_if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h3000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IMEM_AW  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  stage_if_prefetch_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_X = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   rpc_q, rpc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   ir_mem_q [DEPTH];

  logic          redirect, resp, req_valid, req_fire, push, pop, valid;
  logic [31:0]   target, head_pc;
  logic [CW:0]   occupancy;

  always_comb begin
    redirect  = bus.ctrl_pc_src_D;
    target    = bus.NPC_D & ~32'h3;
    resp      = bus.imem_resp_valid;
    valid     = (cnt_q != '0);
    occupancy = {1'b0, cnt_q} + {1'b0, outst_q} - {1'b0, drop_q};
    // outst also counts in-flight stale fetches; capping it at DEPTH keeps the
    // counters in range when redirects pile up drops.
    req_valid = rst_n & ~redirect & (occupancy < DEPTH_X) & (outst_q < DEPTH_C);
    req_fire  = req_valid & bus.imem_req_ready;
    push      = resp & (drop_q == '0) & ~redirect;
    pop       = valid & bus.ready_D & ~redirect;

    outst_d = outst_q + CW'(req_fire) - CW'(resp);
    fpc_d   = fpc_q;
    rpc_d   = rpc_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    drop_d  = drop_q;

    if (redirect) begin
      fpc_d  = target;
      rpc_d  = target;
      cnt_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      drop_d = outst_d;
    end else begin
      if (req_fire) fpc_d = fpc_q + 32'd4;
      // Responses return in order, so the pc of the next kept word is the
      // previous kept pc + 4, restarted at every redirect target.
      if (push) rpc_d = rpc_q + 32'd4;
      if (resp && drop_q != '0) drop_d = drop_q - 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      wr_d  = wr_q + PW'(push);
      rd_d  = rd_q + PW'(pop);
    end
  end

  always_comb begin
    head_pc            = pc_mem_q[rd_q];
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = IMEM_AW'(fpc_q);
    bus.valid_F        = valid;
    bus.IR_F           = valid ? ir_mem_q[rd_q] : '0;
    bus.PCInc4_F       = valid ? head_pc + 32'd4 : '0;
    bus.PC             = valid ? head_pc : fpc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      cnt_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_mem_q[wr_q] <= rpc_q;
      ir_mem_q[wr_q] <= bus.imem_resp_data;
    end
  end

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Directed and random checks of stage_if_prefetch against a sequential-PC
// stream model with an in-order, variable-latency memory.
module tb_stage_if_prefetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h3000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stage_if_prefetch_if #(.IMEM_AW(32)) bus ();

  stage_if_prefetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH), .IMEM_AW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned ep;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] deliv[$];

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, rst_cyc = 0, epoch = 0, qn = 0;
  int unsigned n_req = 0, n_pop = 0, n_stale = 0, first_valid_cyc = 0;
  logic [31:0] exp_pc, mfpc, first_req_addr, redir_addr;
  logic        post_reset = 1'b0, first_req_seen = 1'b0, cap_redir = 1'b0;
  logic        redir_resp = 1'b0;

  logic        k_rst_n, k_req_ready, k_ready_D, k_redirect, k_resp_ok, rnd_lat;
  logic [31:0] k_npc;
  int unsigned mem_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_F00F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compare DUT outputs with the model for the current cycle, then advance the model.
  task automatic model_step();
    logic        rd;
    logic        exp_rv;
    int unsigned live;
    int unsigned lat_now;
    mreq_t       e;
    if (!rst_n) begin
      check("rst_req_valid", bus.imem_req_valid, 1'b0);
      memq.delete();
      qn = 0; epoch++;
      exp_pc = RST_PC; mfpc = RST_PC;
      post_reset = 1'b1; rst_cyc = cyc; first_valid_cyc = 0; first_req_seen = 1'b0;
      return;
    end
    if (post_reset) begin
      check("rst_valid_F", bus.valid_F, 1'b0);
      check("rst_IR_F", bus.IR_F, 32'h0);
      check("rst_PCInc4_F", bus.PCInc4_F, 32'h0);
      check("rst_PC", bus.PC, RST_PC);
      check("rst_req_addr", bus.imem_req_addr, RST_PC);
      post_reset = 1'b0;
    end
    rd = bus.ctrl_pc_src_D;
    live = 0;
    foreach (memq[i]) if (memq[i].ep == epoch) live++;

    check("valid_F", bus.valid_F, qn != 0);
    if (qn != 0) begin
      check("IR_F", bus.IR_F, mem_word(exp_pc));
      check("PCInc4_F", bus.PCInc4_F, exp_pc + 32'd4);
      check("PC_head", bus.PC, exp_pc);
    end else begin
      check("IR_F_nop", bus.IR_F, 32'h0);
      check("PCInc4_F_zero", bus.PCInc4_F, 32'h0);
      check("PC_fetch", bus.PC, mfpc);
    end
    if (bus.valid_F && first_valid_cyc == 0) first_valid_cyc = cyc - rst_cyc;

    exp_rv = !rd && (qn + live < DEPTH) && (memq.size() < DEPTH);
    check("req_valid", bus.imem_req_valid, exp_rv);
    if (bus.imem_req_valid) check("req_addr", bus.imem_req_addr, mfpc);

    if (bus.imem_req_valid && bus.imem_req_ready) begin
      if (!first_req_seen) begin first_req_addr = bus.imem_req_addr; first_req_seen = 1'b1; end
      if (cap_redir) begin redir_addr = bus.imem_req_addr; cap_redir = 1'b0; end
      lat_now = rnd_lat ? $urandom_range(1, 6) : mem_lat;
      memq.push_back('{mfpc, cyc + lat_now, epoch});
      mfpc = mfpc + 32'd4;
      n_req++;
    end
    if (bus.imem_resp_valid) begin
      e = memq.pop_front();
      if (rd || e.ep != epoch) n_stale++;
      else qn++;
    end
    if (bus.valid_F && bus.ready_D && !rd && qn != 0) begin
      deliv.push_back(bus.PCInc4_F);
      exp_pc = exp_pc + 32'd4;
      qn--;
      n_pop++;
    end
    if (rd) begin
      epoch++;
      qn = 0;
      exp_pc = bus.NPC_D & ~32'h3;
      mfpc = exp_pc;
      redir_resp = bus.imem_resp_valid;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    rst_n              = k_rst_n;
    bus.ctrl_pc_src_D  = k_redirect;
    bus.NPC_D          = k_npc;
    bus.ready_D        = k_ready_D;
    bus.imem_req_ready = k_req_ready;
    if (k_rst_n && k_resp_ok && memq.size() != 0 && memq[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(memq[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = $urandom;
    end
    @(negedge clk);
    model_step();
    cyc++;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    k_rst_n = 1'b0;
    run(1);
    k_rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
    bus.ctrl_pc_src_D = 1'b0; bus.NPC_D = '0; bus.ready_D = 1'b0;
    k_rst_n = 1'b0; k_req_ready = 1'b1; k_ready_D = 1'b1; k_redirect = 1'b0;
    k_resp_ok = 1'b1; rnd_lat = 1'b0; k_npc = '0; mem_lat = 1;
    exp_pc = RST_PC; mfpc = RST_PC; first_req_addr = '0; redir_addr = '0;

    // 1: latency 1, ID always ready
    run(1);
    do_reset();
    deliv.delete();
    run(10);
    check("t1_first_addr", first_req_addr, 32'h3000);
    check("t1_first_valid_cycle", first_valid_cyc, 3);
    check("t1_deliv0", deliv[0], 32'h3004);
    check("t1_deliv1", deliv[1], 32'h3008);
    check("t1_deliv2", deliv[2], 32'h300C);

    // 2: ID stalled for 20 cycles
    k_ready_D = 1'b0;
    do_reset();
    n_req = 0;
    run(20);
    check("t2_req_count", n_req, 4);
    check("t2_req_valid_low", bus.imem_req_valid, 1'b0);
    check("t2_hold_ir", bus.IR_F, 32'h5A5A_C00F);
    check("t2_hold_pcinc4", bus.PCInc4_F, 32'h3004);
    deliv.delete();
    k_ready_D = 1'b1;
    run(4);
    check("t2_deliv_count", deliv.size(), 4);
    check("t2_deliv0", deliv[0], 32'h3004);
    check("t2_deliv1", deliv[1], 32'h3008);
    check("t2_deliv2", deliv[2], 32'h300C);
    check("t2_deliv3", deliv[3], 32'h3010);

    // 3: latency 5, redirect with three requests in flight
    mem_lat = 5;
    do_reset();
    run(3);
    n_stale = 0;
    deliv.delete();
    cap_redir = 1'b1;
    k_redirect = 1'b1; k_npc = 32'h4002;
    run(1);
    k_redirect = 1'b0;
    run(30);
    check("t3_stale_dropped", n_stale, 3);
    check("t3_next_addr", redir_addr, 32'h4000);
    check("t3_first_deliv", deliv[0], 32'h4004);

    // 4a: redirect against a full queue with ID ready
    mem_lat = 2; k_ready_D = 1'b0;
    do_reset();
    run(12);
    check("t4_queue_full_valid", bus.valid_F, 1'b1);
    deliv.delete();
    k_ready_D = 1'b1; k_redirect = 1'b1; k_npc = 32'h6000;
    run(1);
    k_redirect = 1'b0;
    check("t4_no_pop", deliv.size(), 0);
    run(1);
    check("t4_flushed_valid", bus.valid_F, 1'b0);
    check("t4_flushed_ir", bus.IR_F, 32'h0);
    run(10);
    check("t4_restart", deliv[0], 32'h6004);

    // 4b: redirect in a cycle carrying a response
    mem_lat = 1;
    do_reset();
    run(6);
    deliv.delete();
    k_redirect = 1'b1; k_npc = 32'h5000;
    run(1);
    k_redirect = 1'b0;
    check("t4b_resp_in_redirect", redir_resp, 1'b1);
    run(10);
    check("t4b_restart", deliv[0], 32'h5004);

    // 5: random traffic, including fetches that wrap past 2^32
    rnd_lat = 1'b1;
    n_pop = 0;
    for (int unsigned i = 0; i < 10000; i++) begin
      k_req_ready = ($urandom_range(0, 3) != 0);
      k_ready_D   = ($urandom_range(0, 3) != 0);
      k_resp_ok   = ($urandom_range(0, 4) != 0);
      k_redirect  = ($urandom_range(0, 39) == 0);
      k_npc       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      run(1);
    end
    k_redirect = 1'b0; k_req_ready = 1'b1; k_ready_D = 1'b1; k_resp_ok = 1'b1;
    rnd_lat = 1'b0;
    run(20);
    check("t5_progress", n_pop > 1000, 1'b1);

    // 6: one-cycle reset in the middle of a stream
    run(5);
    deliv.delete();
    k_rst_n = 1'b0;
    run(1);
    k_rst_n = 1'b1;
    run(1);
    check("t6_req_addr", bus.imem_req_addr, 32'h3000);
    check("t6_req_valid", bus.imem_req_valid, 1'b1);
    check("t6_valid_F", bus.valid_F, 1'b0);
    check("t6_pcinc4", bus.PCInc4_F, 32'h0);
    run(10);
    check("t6_restart", deliv[0], 32'h3004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
